int_ctrl18: RTL and testbench

//  Interrupt controller that drives the 4-bit VECTOR input of Core18. Collects 15

---
 rtl/int_ctrl18_pkg.sv | 45 ++++
 rtl/int_ctrl18_sync.sv | 34 +++
 rtl/int_ctrl18.sv | 174 +++++++++++++++++
 tb/tb_int_ctrl18.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl18_pkg.sv
// Shared definitions for the Core18 interrupt controller: widths, register
// offsets, FSM states and the small vector helper functions.
package int_ctrl18_pkg;

  localparam int NUM_IRQ = 15;
  localparam int VEC_W   = 4;
  localparam int DATA_W  = 18;
  localparam int ADRS_W  = 18;
  localparam int PC_W    = 12;

  // Register offsets from the controller's base port address.
  typedef enum logic [1:0] {
    REG_ENABLE  = 2'd0,
    REG_PENDING = 2'd1,
    REG_SET     = 2'd2,
    REG_ACTIVE  = 2'd3
  } reg_off_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POST = 2'd1,
    ST_ACK  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Highest set bit wins; line i maps to vector i+1, 0 means nothing pending.
  function automatic logic [VEC_W-1:0] top_vector(input logic [NUM_IRQ-1:0] cand);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand[i]) v = VEC_W'(i + 1);
    end
    return v;
  endfunction

  // Request-line mask for a vector; vector 0 selects no line.
  function automatic logic [NUM_IRQ-1:0] vec_onehot(input logic [VEC_W-1:0] v);
    logic [NUM_IRQ-1:0] m;
    for (int i = 0; i < NUM_IRQ; i++) begin
      m[i] = (v == VEC_W'(i + 1));
    end
    return m;
  endfunction

endpackage

// File: rtl/int_ctrl18_sync.sv
// One interrupt line: multi-flop synchroniser plus rising-edge detector.
// The edge history is held at 1 until the synchroniser has been refilled after
// reset, so a line that is already high when reset releases is not an edge.
module int_ctrl18_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic primed,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = primed & level & ~hist_q;

  // Shift the raw request through the synchroniser and track last synced value.
  // NOTE: non-blocking (<=) so every flop samples pre-edge values; blocking here
  // would collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      hist_q <= primed ? level : 1'b1;
    end
  end

endmodule

// File: rtl/int_ctrl18.sv
// Core18 interrupt controller: synchronises 15 request lines, latches edges and
// software triggers, masks with ENABLE and posts the highest pending vector on
// VECTOR until the core is seen fetching from that vector address.
module int_ctrl18
  import int_ctrl18_pkg::*;
#(
  parameter logic [ADRS_W-1:0]  BASE_ADRS   = 18'o000100,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = 15'h7FFF,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 GAP_CYCLES  = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [PC_W-1:0]   PC,
  input  logic              PORT_WR,
  input  logic              PORT_RD,
  input  logic [ADRS_W-1:0] ADRS,
  input  logic [DATA_W-1:0] DATAOUT,
  output logic [VEC_W-1:0]  VECTOR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID
);

  // ---------------------------------------------------------------- sync
  logic [3:0]         prime_cnt;
  logic               primed;
  logic [NUM_IRQ-1:0] level;
  logic [NUM_IRQ-1:0] rise;

  assign primed = (prime_cnt == 4'(SYNC_STAGES));

  // Count the cycles needed to refill the synchronisers after reset.
  always_ff @(posedge CLK) begin
    if (RESET)        prime_cnt <= '0;
    else if (!primed) prime_cnt <= prime_cnt + 4'd1;
  end

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    int_ctrl18_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk   (CLK),
      .rst   (RESET),
      .irq   (IRQ[i]),
      .primed(primed),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // ---------------------------------------------------------------- decode
  logic [ADRS_W-1:0]  adrs_off;
  logic               hit;
  reg_off_t           sel;
  logic [NUM_IRQ-1:0] wdata;
  logic               wr_enable, wr_pending, wr_set;
  logic               unused_bits;

  assign adrs_off    = ADRS - BASE_ADRS;
  assign hit         = (adrs_off[ADRS_W-1:2] == '0);
  assign sel         = reg_off_t'(adrs_off[1:0]);
  assign wdata       = DATAOUT[NUM_IRQ-1:0];
  assign wr_enable   = PORT_WR & hit & (sel == REG_ENABLE);
  assign wr_pending  = PORT_WR & hit & (sel == REG_PENDING);
  assign wr_set      = PORT_WR & hit & (sel == REG_SET);
  assign unused_bits = ^DATAOUT[DATA_W-1:NUM_IRQ];

  // ---------------------------------------------------------------- registers
  state_t             state_q;
  logic [VEC_W-1:0]   vector_q;
  logic [VEC_W-1:0]   posted_q;
  logic [7:0]         gap_cnt;
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] latch_q;    // edge-captured and software-set requests
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] set_bits;
  logic [NUM_IRQ-1:0] clr_bits;
  logic [NUM_IRQ-1:0] ack_clr;

  // Level sources show their live synced level; the latch only holds their SET bit.
  assign pending  = latch_q | (level & ~EDGE_MASK);
  assign cand     = pending & enable_q;
  assign ack_clr  = (state_q == ST_ACK) ? vec_onehot(posted_q) : '0;
  assign set_bits = (rise & EDGE_MASK) | (wr_set ? wdata : '0);
  assign clr_bits = (wr_pending ? wdata : '0) | ack_clr;

  // Software-programmed enable mask.
  always_ff @(posedge CLK) begin
    if (RESET)          enable_q <= '0;
    else if (wr_enable) enable_q <= wdata;
  end

  // Request latch: clear by W1C or acknowledge, a same-cycle set always wins.
  always_ff @(posedge CLK) begin
    if (RESET) latch_q <= '0;
    else       latch_q <= (latch_q & ~clr_bits) | set_bits;
  end

  // ---------------------------------------------------------------- FSM
  // Post, hold until fetched or withdrawn, acknowledge, then a quiet gap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      vector_q <= '0;
      posted_q <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cand != '0) begin
            vector_q <= top_vector(cand);
            posted_q <= top_vector(cand);
            state_q  <= ST_POST;
          end
        end
        ST_POST: begin
          if (PC == {{(PC_W-VEC_W){1'b0}}, vector_q}) begin
            vector_q <= '0;
            state_q  <= ST_ACK;
          end else if ((cand & vec_onehot(vector_q)) == '0) begin
            vector_q <= '0;
            state_q  <= ST_IDLE;
          end
        end
        ST_ACK: begin
          vector_q <= '0;
          gap_cnt  <= 8'(GAP_CYCLES);
          state_q  <= ST_GAP;
        end
        ST_GAP: begin
          vector_q <= '0;
          if (gap_cnt <= 8'd1) state_q <= ST_IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: begin
          vector_q <= '0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign VECTOR = vector_q;

  // ---------------------------------------------------------------- read path
  logic [DATA_W-1:0] rd_mux;

  // Select the addressed register's read value.
  // NOTE: default assignment first so every path drives rd_mux; otherwise an
  // unlisted selector would hold the old value and infer a latch.
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_ENABLE:  rd_mux = DATA_W'(enable_q);
      REG_PENDING: rd_mux = DATA_W'(pending);
      REG_ACTIVE:  rd_mux = DATA_W'(vector_q);
      default:     rd_mux = '0;
    endcase
  end

  // Register the read response one cycle after the strobe; misses return zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      RD_VALID <= PORT_RD & hit;
      RD_DATA  <= (PORT_RD & hit) ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_int_ctrl18.sv
// Self-checking bench for int_ctrl18: directed scenarios followed by randomized
// request/enable patterns scored against a request-set model.
module tb_int_ctrl18;

  localparam logic [17:0] BASE      = 18'o000100;
  localparam int          SYNC_ST   = 2;
  localparam logic [14:0] EDGE_MSK  = 15'h7FFE;   // IRQ[0] is a level source
  localparam logic [11:0] PC_IDLE   = 12'o7777;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [14:0] IRQ;
  logic [11:0] PC;
  logic        PORT_WR, PORT_RD;
  logic [17:0] ADRS, DATAOUT;
  logic [3:0]  VECTOR;
  logic [17:0] RD_DATA;
  logic        RD_VALID;

  int          n_cmp = 0;
  int          n_err = 0;

  logic [17:0] rdata;
  logic [14:0] m_en, m_pend, rnd;
  int          t;

  int_ctrl18 #(
    .BASE_ADRS  (BASE),
    .EDGE_MASK  (EDGE_MSK),
    .SYNC_STAGES(SYNC_ST),
    .GAP_CYCLES (2)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IRQ     (IRQ),
    .PC      (PC),
    .PORT_WR (PORT_WR),
    .PORT_RD (PORT_RD),
    .ADRS    (ADRS),
    .DATAOUT (DATAOUT),
    .VECTOR  (VECTOR),
    .RD_DATA (RD_DATA),
    .RD_VALID(RD_VALID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr_raw(input logic [17:0] a, input logic [17:0] d);
    ADRS = a; DATAOUT = d; PORT_WR = 1'b1;
    @(negedge CLK);
    PORT_WR = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [17:0] d);
    wr_raw(BASE + 18'(off), d);
  endtask

  task automatic rd(input string tag, input logic [1:0] off, output logic [17:0] d);
    ADRS = BASE + 18'(off); PORT_RD = 1'b1;
    @(negedge CLK);
    PORT_RD = 1'b0;
    check(tag, 32'(RD_VALID), 32'd1);
    d = RD_DATA;
  endtask

  task automatic pulse(input logic [14:0] m);
    IRQ = IRQ | m;
    @(negedge CLK);
    IRQ = IRQ & ~m;
  endtask

  task automatic wait_vec(input string tag, input logic [3:0] exp, input int budget);
    int n;
    n = 0;
    while (VECTOR !== exp && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(VECTOR), 32'(exp));
  endtask

  task automatic hold_vec(input string tag, input logic [3:0] exp, input int cycles);
    logic [3:0] seen;
    seen = exp;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (VECTOR !== exp) seen = VECTOR;
    end
    check(tag, 32'(seen), 32'(exp));
  endtask

  task automatic ack(input string tag, input logic [3:0] v);
    PC = {8'b0, v};
    @(negedge CLK);
    check(tag, 32'(VECTOR), 32'd0);
    PC = PC_IDLE;
  endtask

  function automatic int top_of(input logic [14:0] c);
    for (int i = 14; i >= 0; i--) begin
      if (c[i]) return i + 1;
    end
    return 0;
  endfunction

  initial begin
    RESET = 1'b1; IRQ = '0; PC = PC_IDLE;
    PORT_WR = 1'b0; PORT_RD = 1'b0; ADRS = '0; DATAOUT = '0;
    repeat (3) @(negedge CLK);
    check("rst_vector", 32'(VECTOR), 32'd0);
    check("rst_rd_valid", 32'(RD_VALID), 32'd0);
    check("rst_rd_data", 32'(RD_DATA), 32'd0);
    RESET = 1'b0;
    repeat (4) @(negedge CLK);

    // Register access basics.
    rd("rd_en0", 2'd0, rdata);     check("enable_rst", 32'(rdata), 32'h0);
    rd("rd_pend0", 2'd1, rdata);   check("pending_rst", 32'(rdata), 32'h0);
    wr(2'd0, 18'h3FFFF);
    rd("rd_en1", 2'd0, rdata);     check("enable_hi_bits", 32'(rdata), 32'h7FFF);
    wr(2'd0, 18'h0);
    wr_raw(BASE + 18'd4, 18'h1234);
    wr_raw(BASE - 18'd1, 18'h1234);
    rd("rd_en2", 2'd0, rdata);     check("enable_miss_wr", 32'(rdata), 32'h0);
    rd("rd_set", 2'd2, rdata);     check("set_reads0", 32'(rdata), 32'h0);
    rd("rd_act", 2'd3, rdata);     check("active_idle", 32'(rdata), 32'h0);
    ADRS = BASE + 18'd4; PORT_RD = 1'b1;
    @(negedge CLK);
    PORT_RD = 1'b0;
    check("miss_valid", 32'(RD_VALID), 32'd0);
    check("miss_data", 32'(RD_DATA), 32'd0);
    // Same-cycle read and write of ENABLE: read returns the old value.
    ADRS = BASE; DATAOUT = 18'h0123; PORT_WR = 1'b1; PORT_RD = 1'b1;
    @(negedge CLK);
    PORT_WR = 1'b0; PORT_RD = 1'b0;
    check("rw_same_old", 32'(RD_DATA), 32'h0);
    rd("rd_en3", 2'd0, rdata);     check("rw_same_new", 32'(rdata), 32'h0123);
    wr(2'd0, 18'h0);

    // 1: single edge request, fetch acknowledge.
    wr(2'd0, 18'h0010);
    pulse(15'h0010);
    wait_vec("t1_post", 4'd5, SYNC_ST + 2);
    ack("t1_ack", 4'd5);
    repeat (2) @(negedge CLK);
    rd("t1_rd", 2'd1, rdata);      check("t1_pending", 32'(rdata), 32'h0);

    // 2: simultaneous requests, highest index first.
    wr(2'd0, 18'h7FFF);
    pulse(15'h0204);
    wait_vec("t2_first", 4'd10, 8);
    rd("t2_rd", 2'd3, rdata);      check("t2_active", 32'(rdata), 32'd10);
    ack("t2_ack1", 4'd10);
    wait_vec("t2_second", 4'd3, 10);
    ack("t2_ack2", 4'd3);

    // 3: level source re-posts after the gap until it drops.
    wr(2'd0, 18'h0001);
    IRQ[0] = 1'b1;
    wait_vec("t3_post", 4'd1, 8);
    ack("t3_ack1", 4'd1);
    hold_vec("t3_gap", 4'd0, 2);
    wait_vec("t3_repost", 4'd1, 6);
    PC = 12'd1; IRQ[0] = 1'b0;
    @(negedge CLK);
    check("t3_ack2", 32'(VECTOR), 32'd0);
    PC = PC_IDLE;
    hold_vec("t3_dropped", 4'd0, 10);
    rd("t3_rd", 2'd1, rdata);      check("t3_pending", 32'(rdata), 32'h0);

    // 4: software trigger, mask, W1C withdraw.
    wr(2'd0, 18'h0);
    wr(2'd2, 18'h0004);
    rd("t4_rd", 2'd1, rdata);      check("t4_pending", 32'(rdata), 32'h0004);
    hold_vec("t4_masked", 4'd0, 4);
    wr(2'd0, 18'h0004);
    wait_vec("t4_post", 4'd3, 6);
    wr(2'd1, 18'h0004);
    wait_vec("t4_w1c", 4'd0, 2);
    hold_vec("t4_stays0", 4'd0, 6);

    // 5: no preemption by a higher request.
    wr(2'd0, 18'h4010);
    pulse(15'h0010);
    wait_vec("t5_post", 4'd5, 8);
    pulse(15'h4000);
    hold_vec("t5_hold", 4'd5, 8);
    ack("t5_ack", 4'd5);
    wait_vec("t5_next", 4'd15, 10);
    ack("t5_ack15", 4'd15);

    // 6: reset while posted; line held high through reset is not an edge.
    wr(2'd0, 18'h0040);
    IRQ[6] = 1'b1;
    wait_vec("t6_post", 4'd7, 8);
    RESET = 1'b1;
    @(negedge CLK);
    check("t6_rst_vec", 32'(VECTOR), 32'd0);
    RESET = 1'b0;
    rd("t6_rd_en", 2'd0, rdata);   check("t6_enable", 32'(rdata), 32'h0);
    rd("t6_rd_pd", 2'd1, rdata);   check("t6_pending", 32'(rdata), 32'h0);
    wr(2'd0, 18'h7FFF);
    hold_vec("t6_no_edge", 4'd0, 12);
    IRQ[6] = 1'b0;
    repeat (4) @(negedge CLK);

    // Randomized: requests collected with ENABLE=0, then unmasked and serviced.
    m_pend = '0;
    for (int it = 0; it < 25; it++) begin
      wr(2'd0, 18'h0);
      m_en = '0;
      rnd = 15'($urandom) & EDGE_MSK;
      if (rnd != '0) pulse(rnd);
      m_pend = m_pend | rnd;
      repeat (SYNC_ST + 3) @(negedge CLK);
      if ($urandom_range(0, 3) == 0) begin
        rnd = 15'($urandom);
        wr(2'd2, 18'(rnd));
        m_pend = m_pend | rnd;
      end
      if ($urandom_range(0, 3) == 0) begin
        rnd = 15'($urandom);
        wr(2'd1, 18'(rnd));
        m_pend = m_pend & ~rnd;
      end
      m_en = 15'($urandom);
      wr(2'd0, 18'(m_en));
      while ((m_pend & m_en) != '0) begin
        t = top_of(m_pend & m_en);
        wait_vec("rnd_vec", 4'(t), 12);
        ack("rnd_ack", 4'(t));
        m_pend = m_pend & ~(15'(1) << (t - 1));
      end
      hold_vec("rnd_idle", 4'd0, 8);
      rd("rnd_rd", 2'd1, rdata);
      check("rnd_pending", 32'(rdata), 32'(m_pend));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
